cerradura_2bit: RTL and testbench

Sequential combination lock that sits directly downstream of the 2-bit equality comparator. It drives the comparator's B operand with the expected code digit. It consumes the comparator's equality output each time the user presses enter, and steps through a 3-digit code. On success it raises `abierto` for a fixed time. After repeated failures it enters a timed lockout.

---
 rtl/cerradura_2bit.sv | 156 +++++++++++++++
 tb/tb_cerradura_2bit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cerradura_2bit.sv
// cerradura_2bit: three-digit combination lock fed by an external 2-bit
// equality comparator. The expected digit is presented on digito_esp, each
// rising edge of enter consumes the comparator result, a correct code opens
// the lock for a fixed time, and too many wrong entries cause a timed lockout.
module cerradura_2bit #(
  parameter logic [1:0]  CODE0       = 2'd2,
  parameter logic [1:0]  CODE1       = 2'd1,
  parameter logic [1:0]  CODE2       = 2'd3,
  parameter int unsigned MAX_FAILS   = 32'd3,
  parameter int unsigned OPEN_CYCLES = 32'd50_000_000,
  parameter int unsigned LOCK_CYCLES = 32'd150_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       AyB,
  output logic [1:0] digito_esp,
  output logic       abierto,
  output logic       bloqueado,
  output logic [1:0] progreso,
  output logic [1:0] fallos
);

  localparam int unsigned MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_CYC) + 32'd1;

  // Timers count down to zero inclusive, so load with duration minus one.
  localparam logic [CW-1:0] OPEN_LOAD = CW'(OPEN_CYCLES - 32'd1);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [1:0]    MAX_F     = MAX_FAILS[1:0];

  typedef enum logic [2:0] {
    D0      = 3'd0,
    D1      = 3'd1,
    D2      = 3'd2,
    ABIERTO = 3'd3,
    BLOQUEO = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic [1:0]    fallos_r;
  logic [1:0]    fallos_s;
  logic [1:0]    fallos_inc_s;
  logic          enter_q_r;
  logic          press_s;
  logic [1:0]    digito_s;
  logic [1:0]    progreso_s;
  logic          abierto_s;
  logic          bloqueado_s;

  // A press is the rising edge of enter; enter_q starts high so a held
  // button across reset release is not counted.
  assign press_s      = enter & ~enter_q_r;
  assign fallos_inc_s = fallos_r + 2'd1;

  // Next state, timer and failure counter.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    fallos_s = fallos_r;
    case (state_r)
      D0, D1, D2: begin
        if (press_s) begin
          if (AyB) begin
            if (state_r == D0) begin
              state_s = D1;
            end else if (state_r == D1) begin
              state_s = D2;
            end else begin
              state_s  = ABIERTO;
              fallos_s = 2'd0;
              cnt_s    = OPEN_LOAD;
            end
          end else begin
            fallos_s = fallos_inc_s;
            if (fallos_inc_s == MAX_F) begin
              state_s = BLOQUEO;
              cnt_s   = LOCK_LOAD;
            end else begin
              state_s = D0;
            end
          end
        end else begin
          state_s = state_r;
        end
      end
      ABIERTO: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = D0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      BLOQUEO: begin
        if (cnt_r == CNT_ZERO) begin
          state_s  = D0;
          fallos_s = 2'd0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_s  = D0;
        cnt_s    = CNT_ZERO;
        fallos_s = 2'd0;
      end
    endcase
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    digito_s    = CODE0;
    progreso_s  = 2'd0;
    abierto_s   = 1'b0;
    bloqueado_s = 1'b0;
    case (state_s)
      D0:      begin digito_s = CODE0; progreso_s = 2'd0; end
      D1:      begin digito_s = CODE1; progreso_s = 2'd1; end
      D2:      begin digito_s = CODE2; progreso_s = 2'd2; end
      ABIERTO: begin abierto_s = 1'b1; end
      BLOQUEO: begin bloqueado_s = 1'b1; end
      default: begin digito_s = CODE0; end
    endcase
  end

  // State, timer, edge detector and registered outputs; reset wins over all.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= D0;
      cnt_r      <= CNT_ZERO;
      fallos_r   <= 2'd0;
      enter_q_r  <= 1'b1;
      digito_esp <= CODE0;
      progreso   <= 2'd0;
      abierto    <= 1'b0;
      bloqueado  <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      fallos_r   <= fallos_s;
      enter_q_r  <= enter;
      digito_esp <= digito_s;
      progreso   <= progreso_s;
      abierto    <= abierto_s;
      bloqueado  <= bloqueado_s;
    end
  end

  assign fallos = fallos_r;

endmodule

// File: tb/tb_cerradura_2bit.sv
// Testbench for cerradura_2bit: directed scenarios followed by random
// stimulus, every cycle compared against a behavioural lock model.
module tb_cerradura_2bit;

  localparam int OPEN_C = 4;
  localparam int LOCK_C = 6;
  localparam int MAXF   = 3;

  logic       clk;
  logic       reset;
  logic       enter;
  logic       AyB;
  logic [1:0] digito_esp;
  logic       abierto;
  logic       bloqueado;
  logic [1:0] progreso;
  logic [1:0] fallos;

  cerradura_2bit #(
    .CODE0(2'd2), .CODE1(2'd1), .CODE2(2'd3),
    .MAX_FAILS(32'd3), .OPEN_CYCLES(32'd4), .LOCK_CYCLES(32'd6)
  ) dut (
    .clk(clk), .reset(reset), .enter(enter), .AyB(AyB),
    .digito_esp(digito_esp), .abierto(abierto), .bloqueado(bloqueado),
    .progreso(progreso), .fallos(fallos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: digits accepted, remaining open/lock cycles, failures.
  int code_c [3] = '{2, 1, 3};
  int m_pos   = 0;
  int m_open  = 0;
  int m_lock  = 0;
  int m_fails = 0;
  int m_prev  = 1;

  int total     = 0;
  int passed    = 0;
  int open_seen = 0;
  int lock_seen = 0;

  function automatic logic [1:0] exp_digit();
    if (m_open > 0 || m_lock > 0) return 2'(code_c[0]);
    else return 2'(code_c[m_pos]);
  endfunction

  function automatic logic [1:0] exp_prog();
    if (m_open > 0 || m_lock > 0) return 2'd0;
    else return 2'(m_pos);
  endfunction

  task automatic model_update(input logic r, input logic e, input logic a);
    int press;
    if (r) begin
      m_pos = 0; m_open = 0; m_lock = 0; m_fails = 0; m_prev = 1;
    end else begin
      press  = (e && m_prev == 0) ? 1 : 0;
      m_prev = e ? 1 : 0;
      if (m_open > 0) begin
        m_open--;
      end else if (m_lock > 0) begin
        m_lock--;
        if (m_lock == 0) m_fails = 0;
      end else if (press == 1) begin
        if (a) begin
          if (m_pos == 2) begin
            m_pos = 0; m_fails = 0; m_open = OPEN_C;
          end else begin
            m_pos++;
          end
        end else begin
          m_fails++;
          m_pos = 0;
          if (m_fails == MAXF) m_lock = LOCK_C;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, expv);
  endtask

  task automatic check_all();
    chk("digito_esp", digito_esp, exp_digit());
    chk("progreso", progreso, exp_prog());
    chk("fallos", fallos, 2'(m_fails));
    chk("abierto", {1'b0, abierto}, (m_open > 0) ? 2'd1 : 2'd0);
    chk("bloqueado", {1'b0, bloqueado}, (m_lock > 0) ? 2'd1 : 2'd0);
    if (abierto === 1'b1) open_seen++;
    if (bloqueado === 1'b1) lock_seen++;
  endtask

  // One clock: drive inputs, comparator result from the switches, then check.
  task automatic step(input logic r, input logic e, input logic [1:0] sw);
    reset = r;
    enter = e;
    AyB   = (sw == exp_digit());
    @(posedge clk);
    model_update(r, e, AyB);
    #1;
    check_all();
  endtask

  task automatic press(input logic [1:0] sw);
    step(1'b0, 1'b0, sw);
    step(1'b0, 1'b1, sw);
  endtask

  initial begin
    reset = 1'b1; enter = 1'b1; AyB = 1'b0;

    // Reset with enter held, then release with enter still high.
    step(1'b1, 1'b1, 2'd0);
    step(1'b1, 1'b1, 2'd0);
    step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b1, 2'd2);

    // Correct code opens for exactly OPEN_C cycles.
    open_seen = 0;
    press(2'd2);
    chk("prog_after_d0", progreso, 2'd1);
    press(2'd1);
    chk("prog_after_d1", progreso, 2'd2);
    press(2'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 2'd0);
    chk("open_len", 2'(open_seen), 2'(OPEN_C));
    chk("open_len_hi", (open_seen == OPEN_C) ? 2'd1 : 2'd0, 2'd1);

    // Three wrong entries lock out; presses during lockout are ignored.
    lock_seen = 0;
    press(2'd2);
    press(2'd0);
    chk("fallos_one", fallos, 2'd1);
    press(2'd0);
    press(2'd0);
    chk("fallos_lock", fallos, 2'd3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 2'd2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0);
    chk("lock_len", (lock_seen == LOCK_C) ? 2'd1 : 2'd0, 2'd1);
    step(1'b1, 1'b0, 2'd0);

    // Held enter counts as a single press.
    step(1'b0, 1'b0, 2'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 2'd2);
    step(1'b0, 1'b0, 2'd2);
    chk("held_prog", progreso, 2'd1);
    step(1'b1, 1'b0, 2'd0);

    // Reset during the second open cycle.
    press(2'd2); press(2'd1); press(2'd3);
    step(1'b0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 2'd0);
    chk("rst_open_ab", {1'b0, abierto}, 2'd0);
    chk("rst_open_dig", digito_esp, 2'd2);
    step(1'b0, 1'b0, 2'd0);

    // One failure, then the full code: failures cleared on opening.
    press(2'd0);
    chk("fail_first", fallos, 2'd1);
    press(2'd2); press(2'd1); press(2'd3);
    chk("open_clears_f", fallos, 2'd0);
    chk("open_now", {1'b0, abierto}, 2'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 2'd0);

    // Random stimulus, biased toward correct digits to reach deep states.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] sw;
      logic       r;
      logic       e;
      sw = ($urandom_range(0, 1) == 0) ? exp_digit() : 2'($urandom_range(0, 3));
      r  = ($urandom_range(0, 79) == 0);
      e  = ($urandom_range(0, 2) == 0);
      step(r, e, sw);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
